// File: rtl/sram_bist.sv
// sram_bist: March-style built-in self-test master for a single-port SRAM.
//
// The test runs four elements over every address:
//   M0 ascending  : write P
//   M1 ascending  : read (expect P),  write ~P
//   M2 descending : read (expect ~P), write P
//   M3 ascending  : read (expect P),  no write
// On the first mismatch the failing location, expected word and read word
// are captured, the write of that cycle is suppressed and the test ends.
//
// Ports:
//   clk        rising-edge clock, shared with the SRAM
//   rst_n      asynchronous active-low reset
//   start      one-cycle launch pulse, ignored unless idle
//   busy       test in progress (SRAM port owned by the BIST)
//   done       test finished; held until the next accepted start
//   fail       mismatch found (valid with done)
//   fail_addr  address of the first mismatch
//   fail_exp   expected word at the first mismatch
//   fail_got   word read at the first mismatch
//   we         SRAM write enable
//   addr       SRAM address
//   wdata      SRAM write data
//   rdata      SRAM read data, valid the cycle after a read address
//
// SRAM handshake: the SRAM has no valid/ready; a read address presented in
// an *_R state (we=0) yields rdata in the following *_CW / *_C state, which
// is the only cycle the data is compared.
module sram_bist #(
  parameter int unsigned          ADDR_W  = 4,
  parameter int unsigned          DATA_W  = 16,
  parameter logic [DATA_W-1:0]    PATTERN = 16'hAAAA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_M0_W  = 4'd1;
  localparam logic [3:0] S_M1_R  = 4'd2;
  localparam logic [3:0] S_M1_CW = 4'd3;
  localparam logic [3:0] S_M2_R  = 4'd4;
  localparam logic [3:0] S_M2_CW = 4'd5;
  localparam logic [3:0] S_M3_R  = 4'd6;
  localparam logic [3:0] S_M3_C  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [ADDR_W-1:0] A_ZERO = '0;
  localparam logic [ADDR_W-1:0] A_LAST = '1;
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_W-1:0] fail_got_q, fail_got_d;

  logic              cmp_en;
  logic [DATA_W-1:0] exp_word;
  logic              mismatch;

  // Which compare is active and what it expects.
  always_comb begin
    cmp_en   = 1'b0;
    exp_word = PATTERN;
    case (state_q)
      S_M1_CW: begin cmp_en = 1'b1; exp_word = PATTERN;  end
      S_M2_CW: begin cmp_en = 1'b1; exp_word = ~PATTERN; end
      S_M3_C:  begin cmp_en = 1'b1; exp_word = PATTERN;  end
      default: begin cmp_en = 1'b0; exp_word = PATTERN;  end
    endcase
  end

  assign mismatch = cmp_en && (rdata != exp_word);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_M0_W;
          addr_d      = A_ZERO;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_got_d  = '0;
        end
      end
      S_M0_W: begin
        if (addr_q == A_LAST) begin
          state_d = S_M1_R;
          addr_d  = A_ZERO;
        end else begin
          addr_d  = addr_q + A_ONE;
        end
      end
      S_M1_R: state_d = S_M1_CW;
      S_M1_CW: begin
        if (addr_q == A_LAST) begin
          state_d = S_M2_R;
          addr_d  = A_LAST;      // M2 walks downward
        end else begin
          state_d = S_M1_R;
          addr_d  = addr_q + A_ONE;
        end
      end
      S_M2_R: state_d = S_M2_CW;
      S_M2_CW: begin
        if (addr_q == A_ZERO) begin
          state_d = S_M3_R;
          addr_d  = A_ZERO;
        end else begin
          state_d = S_M2_R;
          addr_d  = addr_q - A_ONE;
        end
      end
      S_M3_R: state_d = S_M3_C;
      S_M3_C: begin
        if (addr_q == A_LAST) begin
          state_d = S_DONE;
          addr_d  = A_ZERO;
        end else begin
          state_d = S_M3_R;
          addr_d  = addr_q + A_ONE;
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here.
        state_d = S_IDLE;
        addr_d  = A_ZERO;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = A_ZERO;
      end
    endcase

    // First mismatch overrides the normal walk and ends the test.
    if (mismatch) begin
      state_d     = S_DONE;
      addr_d      = A_ZERO;
      fail_d      = 1'b1;
      fail_addr_d = addr_q;
      fail_exp_d  = exp_word;
      fail_got_d  = rdata;
    end

    if (state_d == S_DONE) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
    end
  end

  // SRAM port is decoded straight from the state register so that an
  // asynchronous reset removes we immediately, and so a mismatch can
  // cancel the write of its own cycle.
  always_comb begin
    we    = 1'b0;
    wdata = '0;
    case (state_q)
      S_M0_W:  begin we = 1'b1;      wdata = PATTERN;  end
      S_M1_CW: begin we = !mismatch; wdata = ~PATTERN; end
      S_M2_CW: begin we = !mismatch; wdata = PATTERN;  end
      default: begin we = 1'b0;      wdata = '0;       end
    endcase
  end

  // addr_q is forced to zero on every entry to DONE/IDLE.
  assign addr      = addr_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;

endmodule

// File: tb/tb_sram_bist.sv
// Testbench for sram_bist: behavioural 16x16 SRAM with injectable faults,
// scoreboard of expected run results, per-scenario test tasks.
module tb_sram_bist;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] P = 16'hAAAA;
  // {busy cycles[7:0], sram writes[7:0], fail, fail_addr, fail_exp, fail_got}
  localparam int RW = 8 + 8 + 1 + AW + DW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail, we;
  logic [AW-1:0] fail_addr, addr;
  logic [DW-1:0] fail_exp, fail_got, wdata, rdata;

  int tests = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sram_bist #(.ADDR_W(AW), .DATA_W(DW), .PATTERN(P)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
    .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  // ------------------------------------------------------------ SRAM model
  // fault_mode: 0 none, 1 addr5 bit0 stuck-at-0, 2 addr0 bit15 stuck-at-0,
  //             3 write to addr 2 also writes addr 3
  logic [DW-1:0] mem[DEPTH];
  int fault_mode = 0;
  int wr_cnt = 0;
  int wr_after_done = 0;

  function automatic logic [DW-1:0] stuck(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (fault_mode == 1 && a == 4'd5) r[0] = 1'b0;
    if (fault_mode == 2 && a == 4'd0) r[15] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (we) begin
      mem[addr] <= stuck(addr, wdata);
      if (fault_mode == 3 && addr == 4'd2) mem[3] <= stuck(4'd3, wdata);
      wr_cnt = wr_cnt + 1;
      if (done) wr_after_done = wr_after_done + 1;
    end
    rdata <= stuck(addr, mem[addr]);
  end

  // -------------------------------------------------------------- drivers
  // Pulses start, then follows the run until done; optional extra start
  // pulses are issued in the busy cycles numbered pulse_a / pulse_b.
  task automatic run_bist(input int pulse_a, input int pulse_b,
                          output int busy_cnt, output bit timed_out);
    wr_cnt = 0;
    wr_after_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
      start = busy && (busy_cnt == pulse_a || busy_cnt == pulse_b);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Runs one test, compares against the next scoreboard entry.
  task automatic run_and_score(input string name, input int pulse_a, input int pulse_b);
    int bc;
    bit to;
    logic [RW-1:0] got, expv;
    run_bist(pulse_a, pulse_b, bc, to);
    tests++;
    if (to) begin
      errors++;
      $display("FAIL %s_timeout: done never rose (busy cycles %0d)", name, bc);
    end
    got  = {8'(bc), 8'(wr_cnt), fail, fail_addr, fail_exp, fail_got};
    expv = exp_q.pop_front();
    tests++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s_result: got busy=%0d wr=%0d fail=%0b addr=%0d exp=%h rd=%h, want busy=%0d wr=%0d fail=%0b addr=%0d exp=%h rd=%h",
               name, got[RW-1-:8], got[RW-9-:8], got[2*DW+AW], got[2*DW+AW-1-:AW], got[2*DW-1-:DW], got[DW-1:0],
               expv[RW-1-:8], expv[RW-9-:8], expv[2*DW+AW], expv[2*DW+AW-1-:AW], expv[2*DW-1-:DW], expv[DW-1:0]);
    end
    tests++;
    if (wr_after_done !== 0) begin
      errors++;
      $display("FAIL %s_write_after_end: got %0d writes, want 0", name, wr_after_done);
    end
  endtask

  function automatic logic [RW-1:0] pack(input int bc, input int wc, input logic f,
                                         input logic [AW-1:0] a, input logic [DW-1:0] e,
                                         input logic [DW-1:0] g);
    return {8'(bc), 8'(wc), f, a, e, g};
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, fail, we, addr, wdata, fail_addr, fail_exp, fail_got} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got busy=%b done=%b fail=%b we=%b addr=%h wdata=%h, want all 0",
               busy, done, fail, we, addr, wdata);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, fail, we, addr, wdata, fail_addr, fail_exp, fail_got} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b fail=%b we=%b addr=%h wdata=%h, want all 0",
               busy, done, fail, we, addr, wdata);
    end
  endtask

  task automatic test_pass();
    fault_mode = 0;
    exp_q.push_back(pack(112, 48, 1'b0, 4'd0, 16'h0000, 16'h0000));
    run_and_score("pass", -1, -1);
    for (int a = 0; a < DEPTH; a++) begin
      tests++;
      if (mem[a] !== P) begin
        errors++;
        $display("FAIL pass_mem[%0d]: got %h, want %h", a, mem[a], P);
      end
    end
    // start during the DONE cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done: got busy=%b done=%b, want busy=0 done=1", busy, done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stuck_addr5();
    logic [DW-1:0] e;
    fault_mode = 1;
    exp_q.push_back(pack(70, 42, 1'b1, 4'd5, 16'h5555, 16'h5554));
    run_and_score("stuck5", -1, -1);
    for (int a = 0; a < DEPTH; a++) begin
      e = (a < 5) ? 16'h5555 : (a == 5) ? 16'h5554 : P;
      tests++;
      if (mem[a] !== e) begin
        errors++;
        $display("FAIL stuck5_mem[%0d]: got %h, want %h", a, mem[a], e);
      end
    end
  endtask

  task automatic test_stuck_addr0();
    fault_mode = 2;
    exp_q.push_back(pack(18, 16, 1'b1, 4'd0, 16'hAAAA, 16'h2AAA));
    run_and_score("stuck0", -1, -1);
  endtask

  task automatic test_coupling();
    fault_mode = 3;
    exp_q.push_back(pack(24, 19, 1'b1, 4'd3, 16'hAAAA, 16'h5555));
    run_and_score("coupling", -1, -1);
  endtask

  task automatic test_start_while_busy();
    fault_mode = 0;
    exp_q.push_back(pack(112, 48, 1'b0, 4'd0, 16'h0000, 16'h0000));
    run_and_score("busy_start", 3, 50);
  endtask

  task automatic test_reset_mid_run();
    int bc;
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    for (int i = 0; i < 200 && bc < 40; i++) begin
      if (busy) bc++;
      if (bc < 40) @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({we, busy, done, fail} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got we=%b busy=%b done=%b fail=%b, want 0000", we, busy, done, fail);
    end
    wr_cnt = 0;
    repeat (2) @(negedge clk);
    tests++;
    if (wr_cnt !== 0) begin
      errors++;
      $display("FAIL reset_writes: got %0d writes during reset, want 0", wr_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(pack(112, 48, 1'b0, 4'd0, 16'h0000, 16'h0000));
    run_and_score("after_reset", -1, -1);
  endtask

  // ----------------------------------------------------------- main flow
  initial begin
    test_reset();
    test_pass();
    test_stuck_addr5();
    test_stuck_addr0();
    test_coupling();
    test_start_while_busy();
    test_reset_mid_run();
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/sram_bist.md
Name: sram_bist

Overview:
- Built-in self-test master for the single-port 16x16 SRAM. It is the initiator on the SRAM port and drives we, addr and wdata.
- Runs a 4-element March test (write, read/invert, read/restore, verify), compares read data against expected values and reports pass/fail plus the first failing location.
- Sits between system control and the SRAM port mux. When busy is low, the SRAM port belongs to functional logic.

Parameters:
- ADDR_W, 4, SRAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 16, SRAM word width.
- PATTERN, 16'hAAAA, background data P; complement ~P is also used.

Ports:
- clk  input  1  rising-edge clock, shared with the SRAM.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that launches a test; ignored while busy=1.
- busy  output  1  high from the cycle after start is accepted until done rises.
- done  output  1  level; set when the test ends, cleared by the next accepted start.
- fail  output  1  valid when done=1; 1 means a mismatch was found.
- fail_addr  output  ADDR_W  address of the first mismatch.
- fail_exp  output  DATA_W  expected word at the first mismatch.
- fail_got  output  DATA_W  word read at the first mismatch.
- we  output  1  SRAM write enable; the SRAM writes on the rising edge.
- addr  output  ADDR_W  SRAM address.
- wdata  output  DATA_W  SRAM write data.
- rdata  input  DATA_W  SRAM read data; synchronous, valid the cycle after addr is presented with we=0.

Behaviour:
- Reset (asynchronous, any time, including mid-test): all outputs go to 0 and the FSM goes to IDLE. No SRAM write may occur after reset asserts.
- States: IDLE, M0_W, M1_R, M1_CW, M2_R, M2_CW, M3_R, M3_C, DONE.
- IDLE: we=0, addr=0, wdata=0. When start=1, clear done/fail/fail_* and set busy; the next state is M0_W with addr=0.
- M0_W, ascending: drive we=1, wdata=P, one cycle per address. At addr=DEPTH-1, go to M1_R with addr=0.
- M1_R, ascending: drive we=0 at addr a.
- M1_CW, same addr a:
  - rdata is valid here; compare it against P.
  - In the same cycle drive we=1, wdata=~P.
  - Then advance to a+1 (M1_R), or, after the last address, go to M2_R with addr=DEPTH-1.
- M2_R / M2_CW: descending; expect ~P, write P. After addr=0, go to M3_R with addr=0.
- M3_R / M3_C: ascending; read, then compare against P with no write. After addr=DEPTH-1, go to DONE.
- Total busy duration: DEPTH + 3*2*DEPTH = 7*DEPTH cycles, i.e. 112 for DEPTH=16.
- Mismatch (in any compare state):
  - Capture fail_addr, fail_exp and fail_got, and set fail=1.
  - Suppress the write in that cycle (we=0).
  - Go to DONE next cycle; the remaining elements are skipped.
- DONE: busy=0, done=1 for one cycle, and the FSM returns to IDLE. done, fail and fail_* hold until the next accepted start. In DONE and IDLE: we=0, addr=0, wdata=0.
- A start pulse while busy=1 is ignored with no effect. A start in the DONE cycle is also ignored.
- Address counters wrap only at element boundaries. The counter never exceeds DEPTH-1 and never underflows below 0 during M2.
- Pass criterion: done=1 and fail=0. fail_* stay 0 on a pass.

Test Plan:
- Reset, then start pulse, with an ideal SRAM model -> busy high for exactly 112 cycles, then done=1, fail=0, fail_addr=0, fail_exp=0, fail_got=0. Memory holds 16'hAAAA at every address.
- Bit 0 of addr 5 stuck-at-0 in the model:
  - M1 reads AAAA OK and writes 5555 (stored as 5554).
  - M2 descending reads addr 5 -> fail=1, fail_addr=5, fail_exp=16'h5555, fail_got=16'h5554.
  - No SRAM write after the mismatch cycle.
- Bit 15 of addr 0 stuck-at-0 -> first compare in M1 at addr 0 fails: fail_addr=0, fail_exp=16'hAAAA, fail_got=16'h2AAA. done rises 18 cycles after start.
- Start pulses in cycles 3 and 50 of a run -> both ignored; timing and result are identical to the first scenario.
- rst_n asserted at cycle 40 of a run -> we, busy, done and fail drop immediately (asynchronously) to 0. After release and a new start, the test completes with a pass.
- Address coupling fault (write to addr 2 also writes addr 3) -> M1 read at addr 3 expects AAAA but got 5555: fail_addr=3, fail_exp=16'hAAAA, fail_got=16'h5555.
